pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter A, default 10, program-counter width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, return-stack entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin execution at PC 0.
REQ-006 SHALL have port halt_op  input  1  decoded halt instruction at current PC.
REQ-007 SHALL have port br_op  input  1  decoded conditional branch.
REQ-008 SHALL have port br_cond  input  1  branch condition result, valid with br_op.
REQ-009 SHALL have port jmp_op  input  1  decoded unconditional jump.
REQ-010 SHALL have port call_op  input  1  decoded call (push return, jump).
REQ-011 SHALL have port ret_op  input  1  decoded return (pop into PC).
REQ-012 SHALL have port Target  input  A  absolute jump/branch/call target.
REQ-013 SHALL have port ProgCtr  output  A  registered program counter.
REQ-014 SHALL have port running  output  1  high while in RUN.
REQ-015 SHALL have port done  output  1  high while in HALTED.
REQ-016 SHALL have port stack_err  output  1  sticky return-stack overflow/underflow flag.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HALTED; all outputs registered.
REQ-018 In IDLE, ProgCtr SHALL hold; start=1 SHALL move to RUN next edge with ProgCtr=0.
REQ-019 In RUN, decode inputs SHALL be sampled every cycle with priority halt_op > ret_op > call_op > jmp_op > (br_op & br_cond) > increment.
REQ-020 halt_op SHALL move to HALTED; ProgCtr holds the halt address.
REQ-021 jmp_op, or br_op with br_cond=1, SHALL load Target next edge; br_op with br_cond=0 SHALL increment.
REQ-022 call_op SHALL push ProgCtr+1 (mod 2^A) and load Target in the same edge.
REQ-023 ret_op SHALL pop the top entry into ProgCtr.
REQ-024 call_op with stack full SHALL set stack_err, not push, and move to HALTED with ProgCtr held.
REQ-025 ret_op with stack empty SHALL set stack_err and move to HALTED with ProgCtr held.
REQ-026 Increment SHALL wrap from 2^A-1 to 0 without error.
REQ-027 In HALTED, start=1 SHALL set ProgCtr=0, empty the stack, and enter RUN; stack_err SHALL remain set.
REQ-028 start SHALL be ignored in RUN; decode inputs SHALL be ignored in IDLE and HALTED.

Reset
REQ-029 Reset SHALL win over all inputs: state IDLE, ProgCtr=0, running=0, done=0, stack_err=0, stack empty.
REQ-030 Reset asserted mid-RUN SHALL discard pending stack contents and take effect at that edge.

Configuration
REQ-031 Macro PC_SEQ_RET_STACK_EN defined SHALL compile in the return stack per REQ-022..REQ-025.
REQ-032 Without PC_SEQ_RET_STACK_EN, call_op SHALL behave as jmp_op, ret_op SHALL be treated as increment, stack_err SHALL be tied 0, no stack storage instantiated.

Structure
REQ-033 Shared package pc_seq_pkg SHALL hold the state enum (IDLE, RUN, HALTED) and default width constants.
REQ-034 Return stack SHALL be sub-module pc_ret_stack (push, pop, full, empty, top), instantiated only under PC_SEQ_RET_STACK_EN.

Verification
REQ-035 Reset, start pulse, 5 idle-decode cycles -> ProgCtr 0,1,2,3,4,5; running=1.
REQ-036 At PC 3 br_op=1 br_cond=1 Target=40 -> PC 40 next; at PC 41 br_op=1 br_cond=0 -> PC 42.
REQ-037 At PC 7 call_op Target=100, at PC 101 ret_op -> PC 100, 101, then 8.
REQ-038 DEPTH+1 nested calls -> last call sets stack_err=1, done=1, PC holds; start -> PC 0, RUN, stack_err stays 1.
REQ-039 halt_op and jmp_op same cycle at PC 9 -> HALTED, PC 9, done=1; Reset -> all outputs 0.
REQ-040 A=4, run from 0 with no ops -> PC 15 then 0, stack_err=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
//   state_t           : sequencer FSM states (IDLE, RUN, HALTED)
//   PC_W_DEF          : default program-counter width in bits
//   RSTACK_DEPTH_DEF  : default number of return-stack entries
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int PC_W_DEF         = 10;
    localparam int RSTACK_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack for the program-counter sequencer (LIFO).
// Only instantiated when PC_SEQ_RET_STACK_EN is defined.
// Ports:
//   clk       in   rising-edge clock
//   Reset     in   synchronous active-high reset, empties the stack
//   clear     in   synchronous empty request (restart from HALTED/IDLE)
//   push      in   write push_data as the new top (ignored when full)
//   pop       in   discard the top entry (ignored when empty)
//   push_data in   A-bit return address to push
//   full      out  DEPTH entries held
//   empty     out  no entries held
//   top       out  current top entry (undefined while empty)
module pc_ret_stack #(
    parameter int A     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [A-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [A-1:0] top
);

    localparam int PW = $clog2(DEPTH);

    logic [A-1:0] r_mem [DEPTH];
    logic [PW:0]  r_cnt;
    logic [PW-1:0] w_wr_idx;
    logic [PW-1:0] w_top_idx;

    // The count has one extra bit so that "full" is distinguishable from
    // "empty"; the low bits double as the write slot.
    assign w_wr_idx  = r_cnt[PW-1:0];
    assign w_top_idx = r_cnt[PW-1:0] - PW'(1);
    assign full      = (r_cnt == (PW+1)'(DEPTH));
    assign empty     = (r_cnt == '0);
    assign top       = r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (Reset || clear) begin
            r_cnt <= '0;
        end else if (push && !full) begin
            r_cnt <= r_cnt + (PW+1)'(1);
        end else if (pop && !empty) begin
            r_cnt <= r_cnt - (PW+1)'(1);
        end
    end

    // Storage carries data only; it is never reset, the count decides validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALTED FSM that advances a registered
// PC by increment, branch, jump, call and return.
// Optional feature macro: PC_SEQ_RET_STACK_EN
//   defined   : call/ret use a DEPTH-entry return stack; overflow/underflow
//               sets the sticky stack_err and halts with PC held.
//   undefined : call acts as jump, ret acts as increment, stack_err = 0.
// Ports:
//   clk       in   rising-edge clock
//   Reset     in   synchronous active-high reset
//   start     in   begin execution at PC 0 (IDLE/HALTED only)
//   halt_op   in   decoded halt
//   br_op     in   decoded conditional branch
//   br_cond   in   branch condition, valid with br_op
//   jmp_op    in   decoded unconditional jump
//   call_op   in   decoded call
//   ret_op    in   decoded return
//   Target    in   A-bit absolute target
//   ProgCtr   out  registered program counter
//   running   out  high while in RUN
//   done      out  high while in HALTED
//   stack_err out  sticky return-stack overflow/underflow flag
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int A     = PC_W_DEF,
    parameter int DEPTH = RSTACK_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         start,
    input  logic         halt_op,
    input  logic         br_op,
    input  logic         br_cond,
    input  logic         jmp_op,
    input  logic         call_op,
    input  logic         ret_op,
    input  logic [A-1:0] Target,
    output logic [A-1:0] ProgCtr,
    output logic         running,
    output logic         done,
    output logic         stack_err
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("pc_sequencer: DEPTH must be a power of two >= 2");
    end

    state_t       r_state;
    state_t       w_state_nxt;
    logic [A-1:0] r_pc;
    logic [A-1:0] w_pc_nxt;
    logic [A-1:0] w_pc_inc;
    logic         r_running;
    logic         r_done;

    // Increment wraps naturally at 2^A.
    assign w_pc_inc = r_pc + A'(1);

`ifdef PC_SEQ_RET_STACK_EN
    logic         r_err;
    logic         w_err_nxt;
    logic         w_push;
    logic         w_pop;
    logic         w_clear;
    logic         w_full;
    logic         w_empty;
    logic [A-1:0] w_top;

    pc_ret_stack #(
        .A     (A),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .Reset     (Reset),
        .clear     (w_clear),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .full      (w_full),
        .empty     (w_empty),
        .top       (w_top)
    );
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
`ifdef PC_SEQ_RET_STACK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_running <= (w_state_nxt == RUN);
            r_done    <= (w_state_nxt == HALTED);
`ifdef PC_SEQ_RET_STACK_EN
            r_err     <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
`ifdef PC_SEQ_RET_STACK_EN
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clear     = 1'b0;
`endif
        case (r_state)
            IDLE, HALTED: begin
                // Decode inputs are ignored here; only start matters.
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = '0;
`ifdef PC_SEQ_RET_STACK_EN
                    w_clear     = 1'b1;
`endif
                end
            end
            RUN: begin
                if (halt_op) begin
                    w_state_nxt = HALTED;
                end else if (ret_op) begin
`ifdef PC_SEQ_RET_STACK_EN
                    if (w_empty) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = HALTED;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_top;
                    end
`else
                    w_pc_nxt = w_pc_inc;
`endif
                end else if (call_op) begin
`ifdef PC_SEQ_RET_STACK_EN
                    if (w_full) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = HALTED;
                    end else begin
                        w_push   = 1'b1;
                        w_pc_nxt = Target;
                    end
`else
                    w_pc_nxt = Target;
`endif
                end else if (jmp_op || (br_op && br_cond)) begin
                    w_pc_nxt = Target;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ProgCtr = r_pc;
    assign running = r_running;
    assign done    = r_done;
`ifdef PC_SEQ_RET_STACK_EN
    assign stack_err = r_err;
`else
    assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       Reset, start, halt_op, br_op, br_cond, jmp_op, call_op, ret_op;
    logic [9:0] Target;
    logic [9:0] ProgCtr;
    logic       running, done, stack_err;

    logic       Reset4, start4, zero4;
    logic [3:0] Target4;
    logic [3:0] ProgCtr4;
    logic       running4, done4, stack_err4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.A(10), .DEPTH(4)) dut (
        .clk(clk), .Reset(Reset), .start(start), .halt_op(halt_op),
        .br_op(br_op), .br_cond(br_cond), .jmp_op(jmp_op),
        .call_op(call_op), .ret_op(ret_op), .Target(Target),
        .ProgCtr(ProgCtr), .running(running), .done(done),
        .stack_err(stack_err)
    );

    pc_sequencer #(.A(4), .DEPTH(4)) dut4 (
        .clk(clk), .Reset(Reset4), .start(start4), .halt_op(zero4),
        .br_op(zero4), .br_cond(zero4), .jmp_op(zero4),
        .call_op(zero4), .ret_op(zero4), .Target(Target4),
        .ProgCtr(ProgCtr4), .running(running4), .done(done4),
        .stack_err(stack_err4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ops();
        start = 0; halt_op = 0; br_op = 0; br_cond = 0;
        jmp_op = 0; call_op = 0; ret_op = 0;
    endtask

    initial begin
        Reset = 1; clr_ops(); Target = '0;
        Reset4 = 1; start4 = 0; zero4 = 0; Target4 = '0;
        #1;
        tick();
        Reset = 0;
        chk("rst_pc", ProgCtr, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_err", stack_err, 0);

        // Decode ignored in IDLE
        jmp_op = 1; Target = 10'd77;
        tick();
        chk("idle_hold_pc", ProgCtr, 0);
        chk("idle_running", running, 0);

        // Start pulse, then five plain cycles
        jmp_op = 0; start = 1;
        tick();
        start = 0;
        chk("start_pc", ProgCtr, 0);
        chk("start_running", running, 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("inc_pc%0d", i), ProgCtr, i);
        end
        chk("run_running", running, 1);

        // Jump back to 3, take branch to 40, fall through at 41
        jmp_op = 1; Target = 10'd3;
        tick();
        chk("jmp_pc3", ProgCtr, 3);
        jmp_op = 0; br_op = 1; br_cond = 1; Target = 10'd40;
        tick();
        chk("br_taken", ProgCtr, 40);
        br_op = 0; br_cond = 0;
        tick();
        chk("pc41", ProgCtr, 41);
        br_op = 1; br_cond = 0; Target = 10'd200;
        tick();
        chk("br_not_taken", ProgCtr, 42);
        br_op = 0;

        // Call/return
        jmp_op = 1; Target = 10'd7;
        tick();
        chk("jmp_pc7", ProgCtr, 7);
        jmp_op = 0; call_op = 1; Target = 10'd100;
        tick();
        chk("call_pc", ProgCtr, 100);
        call_op = 0;
        tick();
        chk("pc101", ProgCtr, 101);
        ret_op = 1; Target = 10'd300;
        tick();
        ret_op = 0;
`ifdef PC_SEQ_RET_STACK_EN
        chk("ret_pc", ProgCtr, 8);
`else
        chk("ret_as_inc_pc", ProgCtr, 102);
`endif
        // start ignored in RUN
        start = 1;
        tick();
        start = 0;
`ifdef PC_SEQ_RET_STACK_EN
        chk("start_in_run", ProgCtr, 9);
`else
        chk("start_in_run", ProgCtr, 103);
`endif
        chk("start_in_run_running", running, 1);

        // Halt beats jump at PC 9
        jmp_op = 1; Target = 10'd9;
        tick();
        chk("jmp_pc9", ProgCtr, 9);
        halt_op = 1; jmp_op = 1; Target = 10'd50;
        tick();
        halt_op = 0;
        chk("halt_pc", ProgCtr, 9);
        chk("halt_done", done, 1);
        chk("halt_running", running, 0);
        tick();   // jmp_op still high: ignored in HALTED
        jmp_op = 0;
        chk("halted_hold_pc", ProgCtr, 9);
        chk("halted_done", done, 1);

        // Reset wins over start
        Reset = 1; start = 1;
        tick();
        Reset = 0; start = 0;
        chk("rst2_pc", ProgCtr, 0);
        chk("rst2_running", running, 0);
        chk("rst2_done", done, 0);
        chk("rst2_err", stack_err, 0);

        // Nested calls: DEPTH+1
        start = 1;
        tick();
        start = 0;
        for (int k = 1; k <= 4; k++) begin
            call_op = 1; Target = 10'(k * 10 + 10);
            tick();
            chk($sformatf("nest_call%0d", k), ProgCtr, k * 10 + 10);
        end
        call_op = 1; Target = 10'd60;
        tick();
        call_op = 0;
`ifdef PC_SEQ_RET_STACK_EN
        chk("ovf_pc", ProgCtr, 50);
        chk("ovf_err", stack_err, 1);
        chk("ovf_done", done, 1);
`else
        chk("call5_pc", ProgCtr, 60);
        chk("call5_err", stack_err, 0);
        chk("call5_running", running, 1);
        halt_op = 1;
        tick();
        halt_op = 0;
        chk("halt60_done", done, 1);
`endif
        start = 1;
        tick();
        start = 0;
        chk("restart_pc", ProgCtr, 0);
        chk("restart_running", running, 1);
`ifdef PC_SEQ_RET_STACK_EN
        chk("restart_err_sticky", stack_err, 1);
        // Stack was emptied by start: a return now underflows
        ret_op = 1;
        tick();
        ret_op = 0;
        chk("udf_pc", ProgCtr, 0);
        chk("udf_done", done, 1);
        chk("udf_err", stack_err, 1);
`else
        chk("restart_err", stack_err, 0);
        ret_op = 1;
        tick();
        ret_op = 0;
        chk("ret_inc_pc", ProgCtr, 1);
        chk("ret_inc_running", running, 1);
`endif

        // A=4 wrap
        Reset4 = 0; start4 = 1;
        tick();
        start4 = 0;
        chk("w4_start_pc", ProgCtr4, 0);
        for (int i = 1; i <= 15; i++) tick();
        chk("w4_pc15", ProgCtr4, 15);
        tick();
        chk("w4_wrap_pc", ProgCtr4, 0);
        chk("w4_err", stack_err4, 0);
        chk("w4_running", running4, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
